// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, bubble encoding, FSM states, fetch stride.
// The TRAP state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package instruction_fetch_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0] NOP_ENCODING = 32'h00000013;
  localparam logic [PC_WIDTH-1:0]   FETCH_STRIDE = 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, TRAP = 2'd2} fetch_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1} fetch_state_t;
`endif

  function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: flush loads a bubble with pc held, load captures a fetched word,
// otherwise the contents hold.
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_ENCODING
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [INST_WIDTH-1:0] inst_in,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  inst_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      instruction <= NOP_INST;
      inst_valid  <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INST;
      inst_valid  <= 1'b0;
    end else if (load) begin
      pc          <= pc_in;
      instruction <= inst_in;
      inst_valid  <= 1'b1;
    end else begin
      inst_valid  <= inst_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues valid/ready fetches and feeds IF/ID.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]   RESET_PC = 32'h00000000,
  parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_ENCODING
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_en,
  input  logic                  is_stall,
  input  logic                  is_branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_valid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  inst_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_fault
`endif
);

  fetch_state_t        state, next_state;
  logic [PC_WIDTH-1:0] fetch_pc, next_fetch_pc;
  logic                load, flush, transfer, redirect, misaligned;

  assign imem_req  = (state == FETCH) && cpu_en && !(is_stall && inst_valid);
  assign imem_addr = fetch_pc;
  assign transfer  = imem_req && imem_valid;
  assign redirect  = cpu_en && is_branch_taken;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned  = (branch_target[1:0] != 2'b00);
  assign fetch_fault = (state == TRAP);
`else
  assign misaligned  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= next_state;
      fetch_pc <= next_fetch_pc;
    end
  end

  // A redirect outranks stall and any same-cycle transfer; cpu_en low freezes everything.
  always_comb begin
    next_state    = state;
    next_fetch_pc = fetch_pc;
    load          = 1'b0;
    flush         = 1'b0;
    if (!cpu_en) begin
      next_state = state;
    end else begin
      case (state)
        IDLE: begin
          next_state = FETCH;
          if (redirect) begin
            next_fetch_pc = align_word(branch_target);
            flush         = 1'b1;
          end else begin
            flush         = 1'b0;
          end
        end
        FETCH: begin
          if (redirect) begin
            flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              next_state = TRAP;
            end else begin
              next_fetch_pc = align_word(branch_target);
            end
`else
            next_fetch_pc = align_word(branch_target);
`endif
          end else if (transfer) begin
            load          = 1'b1;
            next_fetch_pc = fetch_pc + FETCH_STRIDE;
          end else if (!is_stall) begin
            flush = 1'b1;
          end else begin
            load  = 1'b0;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: begin
          next_state = TRAP;
          flush      = 1'b1;
        end
`endif
        default: begin
          next_state    = IDLE;
          next_fetch_pc = RESET_PC;
          flush         = 1'b1;
        end
      endcase
    end
  end

  if_id_register #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .flush      (flush),
    .pc_in      (fetch_pc),
    .inst_in    (imem_rdata),
    .pc         (pc),
    .instruction(instruction),
    .inst_valid (inst_valid)
  );

endmodule
